// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the line/frame total helper.
package vga_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N position counter for one display axis; wrap flags the increment that returns to 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_H_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/display-enable generator: registered outputs decoded from the current
// (pre-increment) horizontal/vertical position, advancing one pixel per ce.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
  endgenerate

  // One extra bit so sync end positions equal to 1024 still compare correctly.
  localparam int unsigned EW = CNT_W + 1;
  localparam logic [EW-1:0] H_VIS  = EW'(H_ACTIVE);
  localparam logic [EW-1:0] HS_BEG = EW'(H_ACTIVE + H_FP);
  localparam logic [EW-1:0] HS_END = EW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EW-1:0] V_VIS  = EW'(V_ACTIVE);
  localparam logic [EW-1:0] VS_BEG = EW'(V_ACTIVE + V_FP);
  localparam logic [EW-1:0] VS_END = EW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_wrap;
  logic             v_wrap;
  logic [EW-1:0]    hx;
  logic [EW-1:0]    vx;
  logic             in_hs;
  logic             in_vs;
  logic             vis;

  vga_axis_counter #(.MODULUS(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ce),
    .count (hcnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.MODULUS(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .count (vcnt),
    .wrap  (v_wrap)
  );

  a_frame_wrap_on_line_wrap: assert property (@(posedge clk) disable iff (rst)
    v_wrap |-> h_wrap);

  always_comb begin
    hx    = {1'b0, hcnt};
    vx    = {1'b0, vcnt};
    in_hs = (hx >= HS_BEG) && (hx < HS_END);
    in_vs = (vx >= VS_BEG) && (vx < VS_END);
    vis   = (hx < H_VIS) && (vx < V_VIS);
  end

  // Pulses clear every clk; level outputs only move on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        hsync       <= in_hs ? HS_POL : ~HS_POL;
        vsync       <= in_vs ? VS_POL : ~VS_POL;
        de          <= vis;
        x           <= vis ? hcnt : '0;
        y           <= vis ? vcnt : '0;
        line_start  <= (hcnt == '0);
        frame_start <= (hcnt == '0) && (vcnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 line timing (continuous and 1-of-4 ce), and full-frame,
// polarity and mid-frame reset checks on a reduced 16x11 timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic ce_d;
  logic ce_s;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       i_hs, i_vs, i_de, i_ls, i_fs;
  logic [9:0] i_x, i_y;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .ce(ce_d),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // Reduced timing: H 8+2+3+3 = 16, V 6+1+2+2 = 11, frame = 176 pixels.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_sml (
    .clk(clk), .rst(rst), .ce(ce_s),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_inv (
    .clk(clk), .rst(rst), .ce(ce_s),
    .hsync(i_hs), .vsync(i_vs), .de(i_de), .x(i_x), .y(i_y),
    .line_start(i_ls), .frame_start(i_fs)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spot expectations for pixel k of line 0 (k=800 is line 1 pixel 0) on default timing.
  task automatic def_spot(input string pfx, input int k, input bit idle);
    string t;
    t = $sformatf("%s k=%0d", pfx, k);
    case (k)
      0: begin
        check_eq({t, " de"}, d_de, 1); check_eq({t, " x"}, d_x, 0);
        check_eq({t, " y"}, d_y, 0);   check_eq({t, " hs"}, d_hs, 1);
        check_eq({t, " vs"}, d_vs, 1);
        check_eq({t, " ls"}, d_ls, idle ? 0 : 1);
        check_eq({t, " fs"}, d_fs, idle ? 0 : 1);
      end
      1: begin
        check_eq({t, " x"}, d_x, 1); check_eq({t, " ls"}, d_ls, 0);
        check_eq({t, " fs"}, d_fs, 0);
      end
      639: begin check_eq({t, " de"}, d_de, 1); check_eq({t, " x"}, d_x, 639); end
      640: begin check_eq({t, " de"}, d_de, 0); check_eq({t, " x"}, d_x, 0); end
      655: check_eq({t, " hs"}, d_hs, 1);
      656: check_eq({t, " hs"}, d_hs, 0);
      751: check_eq({t, " hs"}, d_hs, 0);
      752: check_eq({t, " hs"}, d_hs, 1);
      800: begin
        check_eq({t, " de"}, d_de, 1); check_eq({t, " x"}, d_x, 0);
        check_eq({t, " y"}, d_y, 1);   check_eq({t, " vs"}, d_vs, 1);
        check_eq({t, " ls"}, d_ls, idle ? 0 : 1);
        check_eq({t, " fs"}, d_fs, 0);
      end
      default: ;
    endcase
  endtask

  task automatic sml_spot(input int k);
    string t;
    t = $sformatf("sml k=%0d", k);
    case (k)
      0: begin
        check_eq({t, " fs"}, s_fs, 1); check_eq({t, " ls"}, s_ls, 1);
        check_eq({t, " de"}, s_de, 1); check_eq({t, " hs"}, s_hs, 1);
        check_eq({t, " vs"}, s_vs, 1); check_eq({t, " inv hs"}, i_hs, 0);
        check_eq({t, " inv vs"}, i_vs, 0); check_eq({t, " inv de"}, i_de, 1);
      end
      10: begin check_eq({t, " hs"}, s_hs, 0); check_eq({t, " inv hs"}, i_hs, 1); end
      13: check_eq({t, " hs"}, s_hs, 1);
      16: begin
        check_eq({t, " ls"}, s_ls, 1); check_eq({t, " fs"}, s_fs, 0);
        check_eq({t, " y"}, s_y, 1);
      end
      87: begin
        check_eq({t, " de"}, s_de, 1); check_eq({t, " x"}, s_x, 7);
        check_eq({t, " y"}, s_y, 5);   check_eq({t, " inv x"}, i_x, 7);
        check_eq({t, " inv y"}, i_y, 5);
      end
      88: begin check_eq({t, " de"}, s_de, 0); check_eq({t, " x"}, s_x, 0); end
      96: begin check_eq({t, " de"}, s_de, 0); check_eq({t, " y"}, s_y, 0); end
      111: check_eq({t, " vs"}, s_vs, 1);
      112: begin check_eq({t, " vs"}, s_vs, 0); check_eq({t, " inv vs"}, i_vs, 1); end
      143: check_eq({t, " vs"}, s_vs, 0);
      144: check_eq({t, " vs"}, s_vs, 1);
      176: begin
        check_eq({t, " fs"}, s_fs, 1); check_eq({t, " ls"}, s_ls, 1);
        check_eq({t, " x"}, s_x, 0);   check_eq({t, " y"}, s_y, 0);
      end
      default: ;
    endcase
  endtask

  initial begin
    int de_n, hsl_n, ls_n, fs_n, vsl_n, ihs_n, ivs_n, ide_n;

    rst  = 1'b1;
    ce_d = 1'b0;
    ce_s = 1'b0;
    tick();
    tick();
    check_eq("rst hs", d_hs, 1);  check_eq("rst vs", d_vs, 1);
    check_eq("rst de", d_de, 0);  check_eq("rst x", d_x, 0);
    check_eq("rst y", d_y, 0);    check_eq("rst ls", d_ls, 0);
    check_eq("rst fs", d_fs, 0);
    check_eq("rst inv hs", i_hs, 0); check_eq("rst inv vs", i_vs, 0);

    // Default timing, ce held high for one line plus one pixel.
    rst  = 1'b0;
    ce_d = 1'b1;
    de_n = 0; hsl_n = 0; ls_n = 0; fs_n = 0;
    for (int k = 0; k <= 800; k++) begin
      tick();
      if (k < 800) begin
        de_n += int'(d_de); hsl_n += int'(!d_hs);
        ls_n += int'(d_ls); fs_n += int'(d_fs);
      end
      def_spot("cont", k, 1'b0);
    end
    check_eq("cont de count", de_n, 640);
    check_eq("cont hs low count", hsl_n, 96);
    check_eq("cont ls count", ls_n, 1);
    check_eq("cont fs count", fs_n, 1);
    ce_d = 1'b0;
    tick();
    check_eq("hold ls cleared", d_ls, 0);
    check_eq("hold de", d_de, 1);
    check_eq("hold y", d_y, 1);

    // Reset wins over ce; then ce 1-of-4 clocks.
    rst  = 1'b1;
    ce_d = 1'b1;
    tick();
    check_eq("rst+ce fs", d_fs, 0); check_eq("rst+ce de", d_de, 0);
    check_eq("rst+ce x", d_x, 0);   check_eq("rst+ce y", d_y, 0);
    rst  = 1'b0;
    ce_d = 1'b0;
    tick();
    check_eq("noce fs", d_fs, 0);
    de_n = 0; hsl_n = 0; ls_n = 0; fs_n = 0;
    for (int k = 0; k <= 800; k++) begin
      for (int j = 0; j < 4; j++) begin
        ce_d = (j == 0);
        tick();
        if (k < 800) begin
          de_n += int'(d_de); hsl_n += int'(!d_hs);
          ls_n += int'(d_ls); fs_n += int'(d_fs);
        end
        def_spot(j == 0 ? "ce4" : "ce4 idle", k, j != 0);
      end
    end
    ce_d = 1'b0;
    check_eq("ce4 de clocks", de_n, 2560);
    check_eq("ce4 hs low clocks", hsl_n, 384);
    check_eq("ce4 ls clocks", ls_n, 1);
    check_eq("ce4 fs clocks", fs_n, 1);

    // Reduced timing: one full frame plus the first pixel of the next.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    ce_s = 1'b1;
    de_n = 0; hsl_n = 0; vsl_n = 0; fs_n = 0; ihs_n = 0; ivs_n = 0; ide_n = 0;
    for (int k = 0; k <= 176; k++) begin
      tick();
      if (k < 176) begin
        de_n  += int'(s_de); hsl_n += int'(!s_hs); vsl_n += int'(!s_vs);
        fs_n  += int'(s_fs); ihs_n += int'(i_hs);  ivs_n += int'(i_vs);
        ide_n += int'(i_de);
      end
      sml_spot(k);
    end
    check_eq("frame de count", de_n, 48);
    check_eq("frame hs low count", hsl_n, 33);
    check_eq("frame vs low count", vsl_n, 32);
    check_eq("frame fs count", fs_n, 1);
    check_eq("inv hs high count", ihs_n, 33);
    check_eq("inv vs high count", ivs_n, 32);
    check_eq("inv de count", ide_n, 48);

    // Run into frame 2 line 7 (vsync), reset on the cycle presenting pixel (5,7).
    for (int k = 177; k <= 292; k++) tick();
    check_eq("pre-rst vs", s_vs, 0);
    rst = 1'b1;
    tick();
    check_eq("mid rst hs", s_hs, 1); check_eq("mid rst vs", s_vs, 1);
    check_eq("mid rst de", s_de, 0); check_eq("mid rst x", s_x, 0);
    check_eq("mid rst y", s_y, 0);   check_eq("mid rst ls", s_ls, 0);
    check_eq("mid rst fs", s_fs, 0); check_eq("mid rst inv vs", i_vs, 0);
    rst  = 1'b0;
    ce_s = 1'b0;
    tick();
    check_eq("post rst idle fs", s_fs, 0);
    check_eq("post rst idle de", s_de, 0);
    ce_s = 1'b1;
    tick();
    check_eq("restart fs", s_fs, 1); check_eq("restart ls", s_ls, 1);
    check_eq("restart de", s_de, 1); check_eq("restart x", s_x, 0);
    check_eq("restart y", s_y, 0);   check_eq("restart vs", s_vs, 1);
    tick();
    check_eq("restart+1 x", s_x, 1); check_eq("restart+1 fs", s_fs, 0);
    ce_s = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
